hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencer that drives the per-stage stall_C/flush_C vectors consumed by pc and the
//   IF/ID, ID/EX and EX/MEM pipeline registers. Bit map: [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM.
//   Resolves load-use hazards, taken branches, exceptions, multi-cycle EX ops and memory wait
//   states. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//   MC_LAT      4   cycles a multi-cycle EX op (mul/div) occupies EX; legal range 2..15
//   MEM_TIMEOUT 16  max MEM_WAIT cycles before forced release; legal range 2..255
// PORTS
//   clk           in   1   single clock, rising edge
//   rst           in   1   synchronous, active-high reset
//   id_rs,id_rt   in   5   source regs of the instruction in ID
//   ex_memread    in   1   instruction in EX is a load
//   ex_rt         in   5   load destination reg in EX
//   branch_taken  in   1   EX resolved a taken branch/jump this cycle
//   exc_req       in   1   exception/restart request, 1-cycle pulse
//   mc_start      in   1   EX holds a multi-cycle op, first cycle only
//   mem_req       in   1   MEM stage access pending
//   mem_ready     in   1   memory completes this cycle
//   stall_C       out  4   per-stage hold (1 = keep value)
//   flush_C       out  4   per-stage clear (1 = load INIT/bubble)
//   busy          out  1   FSM not in RUN
//   err_timeout   out  1   1-cycle pulse when MEM_WAIT times out
//   stall_cycles  out  16  count of cycles with stall_C[0]=1, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset: state=RUN, counters=0, stall_C=0, flush_C=0, busy=0, err_timeout=0, stall_cycles=0.
//   FSM states: RUN, MEM_WAIT, MULTI. stall_C/flush_C are combinational from state + inputs.
//   Priority per cycle: exc_req > MEM_WAIT/mem stall > MULTI > branch_taken > load-use.
//   exc_req (any state): flush_C=4'b1111, stall_C=0; next state RUN; mc/timeout counters cleared.
//   RUN:
//   - mem_req && !mem_ready: stall_C=4'b1111, flush_C=0; go MEM_WAIT, tcnt=1.
//   - mem_req && mem_ready: no stall; zero-wait access.
//   - mc_start: stall_C=4'b0111, flush_C=4'b1000 (bubble into EX/MEM); go MULTI, mcnt=MC_LAT-1.
//   - branch_taken: flush_C=4'b0110, stall_C=0. A load-use hazard in the same cycle is ignored
//     (the ID instruction is squashed).
//   - load-use: ex_memread && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt) -> stall_C=4'b0011,
//     flush_C=4'b0100. No state change; one bubble per hazard.
//   - flush_C[0] is asserted only on exc_req.
//   MEM_WAIT:
//   - stall_C=4'b1111, flush_C=0 every cycle; tcnt increments.
//   - mem_ready: outputs released in that same cycle. Next state is MULTI if mcnt!=0, else RUN.
//   - tcnt==MEM_TIMEOUT without mem_ready: err_timeout=1 for one cycle, release as mem_ready.
//   - branch_taken/load-use are ignored while here; EX is held, so they re-present after release.
//   MULTI:
//   - stall_C=4'b0111, flush_C=4'b1000; mcnt decrements each cycle.
//   - mcnt==0: release this cycle (stall_C=0, flush_C=0), next state RUN.
//   - mem_req && !mem_ready: go MEM_WAIT; mcnt keeps decrementing, saturating at 0.
//   - mc_start while in MULTI is ignored.
//   Latency: every decision is same-cycle combinational from registered state; no added delay.
//   busy = (state!=RUN). Counters wrap never: tcnt holds, mcnt floors at 0, stall_cycles saturates.
//   rst mid-MULTI/MEM_WAIT: next cycle in RUN with all outputs 0. Prior stall is not replayed.
// STRUCTURE
//   Shared definitions.v gains: STATE_RUN/STATE_MEM_WAIT/STATE_MULTI encodings and the masks
//   STALL_LOADUSE=4'b0011, FLUSH_LOADUSE=4'b0100, FLUSH_BRANCH=4'b0110, STALL_ALL=4'b1111,
//   STALL_MC=4'b0111, FLUSH_MC=4'b1000, FLUSH_ALL=4'b1111.
//   One sub-module: load_use_detect (pure combinational compare, output hazard bit).
//   Top level holds the FSM, mcnt, tcnt, stall_cycles and the output mux.
// TESTING
//   - ex_memread=1, ex_rt=5, id_rs=5, RUN -> one cycle stall_C=4'b0011, flush_C=4'b0100;
//     next cycle 0/0. Repeat with ex_rt=0 -> no stall.
//   - load-use + branch_taken same cycle -> flush_C=4'b0110, stall_C=0, no stall_cycles increment.
//   - mem_req with mem_ready after 3 cycles -> stall_C=4'b1111 for 3 cycles, busy=1 for 3 cycles,
//     then RUN; stall_cycles += 3.
//   - mem_req, mem_ready never, MEM_TIMEOUT=16 -> err_timeout pulse on the 16th wait cycle,
//     release, RUN.
//   - mc_start, MC_LAT=4 -> stall_C=4'b0111, flush_C=4'b1000 for 4 cycles, then RUN. With a
//     2-cycle mem wait inserted mid-op, resume MULTI only if mcnt!=0.
//   - exc_req during MULTI, and rst during MEM_WAIT -> flush_C=4'b1111 for 1 cycle for exc_req,
//     all outputs 0 after rst; state RUN, counters cleared.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// per-stage stall/flush masks, counter widths and saturating counter helpers.
// Stage bit map for every mask: [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM.
package hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int MCNT_W = 4;   // holds MC_LAT-1, MC_LAT up to 15
  localparam int TCNT_W = 8;   // holds MEM_TIMEOUT, up to 255
  localparam int PERF_W = 16;

  typedef enum logic [1:0] {
    STATE_RUN      = 2'd0,
    STATE_MEM_WAIT = 2'd1,
    STATE_MULTI    = 2'd2
  } state_e;

  localparam logic [3:0] STALL_LOADUSE = 4'b0011;
  localparam logic [3:0] FLUSH_LOADUSE = 4'b0100;
  localparam logic [3:0] FLUSH_BRANCH  = 4'b0110;
  localparam logic [3:0] STALL_ALL     = 4'b1111;
  localparam logic [3:0] STALL_MC      = 4'b0111;
  localparam logic [3:0] FLUSH_MC      = 4'b1000;
  localparam logic [3:0] FLUSH_ALL     = 4'b1111;

  // Down-counter that floors at zero instead of wrapping.
  function automatic logic [MCNT_W-1:0] mcnt_dec(input logic [MCNT_W-1:0] v);
    return (v == '0) ? v : v - MCNT_W'(1);
  endfunction

  // Wait-cycle counter that holds at all-ones instead of wrapping.
  function automatic logic [TCNT_W-1:0] tcnt_inc(input logic [TCNT_W-1:0] v);
    return (v == '1) ? v : v + TCNT_W'(1);
  endfunction

  // Performance counter that saturates at all-ones.
  function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register the
// instruction in ID reads. Register 0 never creates a hazard.
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  assign hazard = ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: produces per-stage stall_C/flush_C from the registered
// FSM state plus this cycle's hazard inputs, with no added latency.
// Priority: exc_req > memory wait > multi-cycle op > taken branch > load-use.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT      = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              ex_memread,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              branch_taken,
  input  logic              exc_req,
  input  logic              mc_start,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic [3:0]        stall_C,
  output logic [3:0]        flush_C,
  output logic              busy,
  output logic              err_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [MCNT_W-1:0] MC_INIT = MCNT_W'(MC_LAT - 1);
  localparam logic [TCNT_W-1:0] TMO     = TCNT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic       load_use;
  logic       mem_stall;
  logic [3:0] stall_c;
  logic [3:0] flush_c;
  logic       tmo;

  hazard_ctrl_load_use_detect u_load_use (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hazard     (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // Next-state, counter updates and the stall/flush decision for this cycle.
  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    tcnt_d         = tcnt_q;
    stall_cycles_d = stall_cycles_q;
    stall_c        = '0;
    flush_c        = '0;
    tmo            = 1'b0;

    if (exc_req) begin
      // Restart: squash everything, abandon any wait or multi-cycle op.
      flush_c = FLUSH_ALL;
      state_d = STATE_RUN;
      mcnt_d  = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        STATE_RUN: begin
          if (mem_stall) begin
            stall_c = STALL_ALL;
            state_d = STATE_MEM_WAIT;
            tcnt_d  = TCNT_W'(1);
          end else if (mc_start) begin
            stall_c = STALL_MC;
            flush_c = FLUSH_MC;
            state_d = STATE_MULTI;
            mcnt_d  = MC_INIT;
          end else if (branch_taken) begin
            // The ID instruction is squashed, so a load-use on it is moot.
            flush_c = FLUSH_BRANCH;
          end else if (load_use) begin
            stall_c = STALL_LOADUSE;
            flush_c = FLUSH_LOADUSE;
          end
        end

        STATE_MEM_WAIT: begin
          // A multi-cycle op interrupted by the wait keeps counting down.
          mcnt_d = mcnt_dec(mcnt_q);
          if (mem_ready || (tcnt_q >= TMO)) begin
            tmo     = !mem_ready;
            tcnt_d  = '0;
            state_d = (mcnt_q != '0) ? STATE_MULTI : STATE_RUN;
          end else begin
            stall_c = STALL_ALL;
            tcnt_d  = tcnt_inc(tcnt_q);
          end
        end

        STATE_MULTI: begin
          mcnt_d = mcnt_dec(mcnt_q);
          if (mem_stall) begin
            stall_c = STALL_ALL;
            state_d = STATE_MEM_WAIT;
            tcnt_d  = TCNT_W'(1);
          end else if (mcnt_q == '0) begin
            state_d = STATE_RUN;
          end else begin
            stall_c = STALL_MC;
            flush_c = FLUSH_MC;
          end
        end

        default: begin
          state_d = STATE_RUN;
          mcnt_d  = '0;
          tcnt_d  = '0;
        end
      endcase
    end

    if (stall_c[0]) begin
      stall_cycles_d = perf_inc(stall_cycles_q);
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= STATE_RUN;
      mcnt_q         <= '0;
      tcnt_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mcnt_q         <= mcnt_d;
      tcnt_q         <= tcnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Outputs are held quiet while reset is asserted so no stall leaks out.
  always_comb begin
    stall_C      = rst ? 4'b0000 : stall_c;
    flush_C      = rst ? 4'b0000 : flush_c;
    err_timeout  = !rst && tmo;
    busy         = !rst && (state_q != STATE_RUN);
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: drives one cycle at a time on the falling
// edge, queues the expected outputs and compares shortly afterwards.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, branch_taken, exc_req, mc_start, mem_req, mem_ready;
  logic [3:0]  stall_C, flush_C;
  logic        busy, err_timeout;
  logic [15:0] stall_cycles;

  logic [9:0]  exp_q[$];
  logic [15:0] perf_exp;
  int          checks;
  int          failures;

  hazard_ctrl #(.MC_LAT(4), .MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .exc_req      (exc_req),
    .mc_start     (mc_start),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .stall_C      (stall_C),
    .flush_C      (flush_C),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .stall_cycles (stall_cycles)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: move to the next falling edge and return all inputs to idle.
  task automatic nxt();
    @(negedge clk);
    id_rs = '0; id_rt = '0; ex_rt = '0; ex_memread = 1'b0;
    branch_taken = 1'b0; exc_req = 1'b0; mc_start = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Scoreboard: queue the expected outputs for the cycle just driven, then
  // pop and compare; also compare the stall-cycle counter against the
  // running count of expected stall_C[0] cycles.
  task automatic chk(input logic [3:0] es, input logic [3:0] ef,
                     input logic eb, input logic et, input string tag);
    logic [9:0] got;
    logic [9:0] want;
    exp_q.push_back({es, ef, eb, et});
    #1;
    got  = {stall_C, flush_C, busy, err_timeout};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s stall_flush_busy_tmo got=%b want=%b", tag, got, want);
    end
    checks++;
    assert (stall_cycles === perf_exp) else begin
      failures++;
      $error("FAIL %s_perf stall_cycles got=%0d want=%0d", tag, stall_cycles, perf_exp);
    end
    if (es[0] && perf_exp != 16'hFFFF) perf_exp++;
  endtask

  initial begin
    logic       mr, hz;
    logic [4:0] r_ex, r_s, r_t;
    checks   = 0;
    failures = 0;
    perf_exp = '0;
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;

    // Reset state
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "reset_state");

    // Load-use on rs, then release; ex_rt=0 never stalls; load-use on rt
    nxt(); ex_memread = 1; ex_rt = 5; id_rs = 5; chk(4'b0011, 4'b0100, 0, 0, "lu_rs");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "lu_after");
    nxt(); ex_memread = 1; ex_rt = 0; id_rs = 0; chk(4'b0000, 4'b0000, 0, 0, "lu_r0");
    nxt(); ex_memread = 1; ex_rt = 7; id_rt = 7; id_rs = 3; chk(4'b0011, 4'b0100, 0, 0, "lu_rt");
    nxt(); ex_memread = 0; ex_rt = 7; id_rt = 7; chk(4'b0000, 4'b0000, 0, 0, "lu_noload");

    // Load-use together with a taken branch: branch wins, no stall counted
    nxt(); ex_memread = 1; ex_rt = 5; id_rs = 5; branch_taken = 1;
    chk(4'b0000, 4'b0110, 0, 0, "lu_branch");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "post_branch");

    // Random load-use patterns from a small register window
    for (int i = 0; i < 10; i++) begin
      nxt();
      mr   = 1'($urandom_range(0, 1));
      r_ex = 5'($urandom_range(0, 3));
      r_s  = 5'($urandom_range(0, 3));
      r_t  = 5'($urandom_range(0, 3));
      ex_memread = mr; ex_rt = r_ex; id_rs = r_s; id_rt = r_t;
      hz = mr && (r_ex != 0) && (r_ex == r_s || r_ex == r_t);
      chk(hz ? 4'b0011 : 4'b0000, hz ? 4'b0100 : 4'b0000, 0, 0, "lu_rand");
    end

    // Zero-wait memory access
    nxt(); mem_req = 1; mem_ready = 1; chk(4'b0000, 4'b0000, 0, 0, "mem_zero");

    // Memory ready after three stalled cycles; branch ignored while waiting
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 0, 0, "mem_enter");
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "mem_w1");
    nxt(); mem_req = 1; branch_taken = 1; chk(4'b1111, 4'b0000, 1, 0, "mem_w2_branch");
    nxt(); mem_req = 1; mem_ready = 1; chk(4'b0000, 4'b0000, 1, 0, "mem_done");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "mem_run");

    // Memory never ready: timeout pulse on the 16th wait cycle
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 0, 0, "tmo_enter");
    for (int i = 1; i <= 15; i++) begin
      nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "tmo_wait");
    end
    nxt(); mem_req = 1; chk(4'b0000, 4'b0000, 1, 1, "tmo_pulse");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "tmo_after");

    // Multi-cycle op: four stall cycles, mc_start while busy is ignored
    nxt(); mc_start = 1; chk(4'b0111, 4'b1000, 0, 0, "mc_start");
    nxt(); chk(4'b0111, 4'b1000, 1, 0, "mc_3");
    nxt(); mc_start = 1; chk(4'b0111, 4'b1000, 1, 0, "mc_2_restart");
    nxt(); branch_taken = 1; chk(4'b0111, 4'b1000, 1, 0, "mc_1_branch");
    nxt(); chk(4'b0000, 4'b0000, 1, 0, "mc_release");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "mc_run");

    // Short memory wait mid-op: op time remains, so MULTI resumes
    nxt(); mc_start = 1; chk(4'b0111, 4'b1000, 0, 0, "mcm_start");
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "mcm_memstall");
    nxt(); mem_req = 1; mem_ready = 1; chk(4'b0000, 4'b0000, 1, 0, "mcm_memdone");
    nxt(); chk(4'b0111, 4'b1000, 1, 0, "mcm_resume");
    nxt(); chk(4'b0000, 4'b0000, 1, 0, "mcm_release");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "mcm_run");

    // Longer memory wait mid-op: op time used up, straight back to RUN
    nxt(); mc_start = 1; chk(4'b0111, 4'b1000, 0, 0, "mcl_start");
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "mcl_memstall");
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "mcl_w1");
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "mcl_w2");
    nxt(); mem_req = 1; mem_ready = 1; chk(4'b0000, 4'b0000, 1, 0, "mcl_memdone");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "mcl_run");

    // Exception during MULTI
    nxt(); mc_start = 1; chk(4'b0111, 4'b1000, 0, 0, "exc_mc_start");
    nxt(); chk(4'b0111, 4'b1000, 1, 0, "exc_mc_3");
    nxt(); exc_req = 1; chk(4'b0000, 4'b1111, 1, 0, "exc_flush");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "exc_run");

    // Exception outranks branch and load-use in RUN
    nxt(); exc_req = 1; branch_taken = 1; ex_memread = 1; ex_rt = 9; id_rs = 9;
    chk(4'b0000, 4'b1111, 0, 0, "exc_prio");

    // Exception outranks a memory wait
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 0, 0, "excm_enter");
    nxt(); mem_req = 1; exc_req = 1; chk(4'b0000, 4'b1111, 1, 0, "excm_flush");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "excm_run");

    // Reset during MEM_WAIT: RUN afterwards, everything cleared
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 0, 0, "rst_enter");
    nxt(); mem_req = 1; chk(4'b1111, 4'b0000, 1, 0, "rst_wait");
    nxt(); mem_req = 1; rst = 1;
    nxt(); rst = 0; perf_exp = '0;
    chk(4'b0000, 4'b0000, 0, 0, "rst_run");
    nxt(); ex_memread = 1; ex_rt = 2; id_rt = 2; chk(4'b0011, 4'b0100, 0, 0, "rst_lu");
    nxt(); chk(4'b0000, 4'b0000, 0, 0, "final_idle");

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
